// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding, master ids and counter width for the bridge bus arbiter
package bus_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DBG = 1'b1;
  localparam int LAT_W = 3;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick
module rr_arb2
  import bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);
  assign grant_valid = |req;
  assign grant_id = (&req) ? ~last_grant : (req[0] ? MST_CPU : MST_DBG);
endmodule

// File: rtl/bridge_bus_arbiter.sv
// bridge_bus_arbiter: round-robin sharing of the bridge CPU port between two masters,
// sequencing each access through address phase, read wait and a one-cycle acknowledge.
module bridge_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] addr_to_bridge,
  output logic              wen_to_bridge,
  output logic [DATA_W-1:0] wdata_to_bridge,
  input  logic [DATA_W-1:0] rdata_from_bridge,
  output logic              busy,
  output logic              owner
);
  state_t state, state_n;
  logic [LAT_W-1:0] cnt;
  logic last_grant, gv, gid, last_acc;
  rr_arb2 u_arb (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .grant_valid(gv),
    .grant_id   (gid)
  );
  // a write needs a single ACCESS cycle; a read waits until the counter drains
  assign last_acc = (state == ACCESS) && (wen_to_bridge || cnt == '0);
  assign busy = state != IDLE;
  assign m0_ack = (state == RESP) && (owner == MST_CPU);
  assign m1_ack = (state == RESP) && (owner == MST_DBG);
  always_comb begin
    state_n = IDLE;
    if (state == IDLE) state_n = gv ? ACCESS : IDLE;
    else if (state == ACCESS) state_n = last_acc ? RESP : ACCESS;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      last_grant <= MST_DBG;
      owner <= MST_CPU;
      addr_to_bridge <= '0;
      wen_to_bridge <= 1'b0;
      wdata_to_bridge <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        wen_to_bridge <= gv && (gid ? m1_wen : m0_wen);
        if (gv) begin
          addr_to_bridge <= gid ? m1_addr : m0_addr;
          wdata_to_bridge <= gid ? m1_wdata : m0_wdata;
          owner <= gid;
          last_grant <= gid;
          cnt <= LAT_W'(READ_LAT - 1);
        end
      end else if (state == ACCESS) begin
        cnt <= last_acc ? cnt : cnt - LAT_W'(1);
        if (last_acc) wen_to_bridge <= 1'b0;
        if (last_acc && !wen_to_bridge && owner == MST_CPU) m0_rdata <= rdata_from_bridge;
        if (last_acc && !wen_to_bridge && owner == MST_DBG) m1_rdata <= rdata_from_bridge;
      end
    end
  end
endmodule

// File: tb/tb_bridge_bus_arbiter.sv
// tb_bridge_bus_arbiter: directed table, corner-case sequences and random traffic
// checked every cycle against a transaction-level timing model.
module tb_bridge_bus_arbiter;
  localparam int RL = 2;
  logic clk, rst;
  logic m0_req, m0_wen, m0_ack, m1_req, m1_wen, m1_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [31:0] addr_to_bridge, wdata_to_bridge, rdata_from_bridge;
  logic wen_to_bridge, busy, owner;

  bridge_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .addr_to_bridge(addr_to_bridge), .wen_to_bridge(wen_to_bridge),
    .wdata_to_bridge(wdata_to_bridge), .rdata_from_bridge(rdata_from_bridge),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int m_free = 0, m_grant = -100, m_ack = -100, m_bcyc = -100;
  bit m_owner = 0, m_wen = 0, m_last = 1;
  logic [31:0] m_addr = 0, m_wdata = 0, m_bdata = 0, bridge_word = 0;
  logic [31:0] exp_rd [2] = '{32'h0, 32'h0};

  typedef struct {
    bit mst; bit wen;
    logic [31:0] addr; logic [31:0] wdata; logic [31:0] bword;
    int lat; logic [31:0] rdata;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", n, cyc, got, exp);
    end
  endtask

  task automatic set_m(input bit i, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (i) begin m1_req = r; m1_wen = w; m1_addr = a; m1_wdata = d; end
    else begin m0_req = r; m0_wen = w; m0_addr = a; m0_wdata = d; end
  endtask

  // One clock: grant decision from this cycle's inputs, bridge response, then check the next cycle.
  task automatic tick();
    bit w, rst_now;
    rst_now = rst;
    if (!rst && cyc >= m_free && (m0_req || m1_req)) begin
      w = (m0_req && m1_req) ? !m_last : m1_req;
      m_owner = w; m_last = w; m_grant = cyc;
      m_wen = w ? m1_wen : m0_wen;
      m_addr = w ? m1_addr : m0_addr;
      m_wdata = w ? m1_wdata : m0_wdata;
      m_bdata = bridge_word;
      m_ack = cyc + (m_wen ? 2 : RL + 1);
      m_free = m_ack + 1;
      m_bcyc = cyc + RL;
    end
    rdata_from_bridge = (cyc == m_bcyc && !m_wen) ? m_bdata : ~m_bdata;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (rst_now) begin
      m_free = cyc; m_grant = -100; m_ack = -100; m_bcyc = -100;
      m_owner = 0; m_wen = 0; m_last = 1; m_addr = 0; m_wdata = 0;
      exp_rd[0] = 0; exp_rd[1] = 0;
    end
    if (cyc == m_ack && !m_wen) exp_rd[m_owner] = m_bdata;
    chk("m0_ack", m0_ack, cyc == m_ack && !m_owner);
    chk("m1_ack", m1_ack, cyc == m_ack && m_owner);
    chk("busy", busy, cyc > m_grant && cyc <= m_ack);
    chk("owner", owner, m_owner);
    chk("addr", addr_to_bridge, m_addr);
    chk("wdata", wdata_to_bridge, m_wdata);
    chk("wen", wen_to_bridge, m_wen && cyc == m_grant + 1);
    chk("m0_rdata", m0_rdata, exp_rd[0]);
    chk("m1_rdata", m1_rdata, exp_rd[1]);
  endtask

  task automatic wait_ack(output bit who);
    int n = 0;
    do begin tick(); n++; end while (!(m0_ack || m1_ack) && n < 30);
    if (!(m0_ack || m1_ack)) begin
      checks++; errors++;
      $display("FAIL ack_timeout cycle %0d got no ack expected ack within 30 cycles", cyc);
    end
    who = m1_ack;
  endtask

  initial begin
    bit who, on [2], pend [2], rwen [2];
    logic [31:0] ra [2], rw [2], rd;
    int n, acks;
    tbl[0] = '{1'b0, 1'b1, 32'hFFFF_F000, 32'h1234_5678, 32'h0, 2, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, RL + 1, 32'hDEAD_BEEF};
    tbl[2] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0, 32'hCAFE_F00D, RL + 1, 32'hCAFE_F00D};
    tbl[3] = '{1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 32'h0, 2, 32'hDEAD_BEEF};
    tbl[4] = '{1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0, 2, 32'hCAFE_F00D};
    rst = 1'b1;
    set_m(0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0);
    rdata_from_bridge = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      set_m(tbl[k].mst, 1, tbl[k].wen, tbl[k].addr, tbl[k].wdata);
      bridge_word = tbl[k].bword;
      n = 0; rd = 0;
      do begin
        tick(); n++;
      end while (!(tbl[k].mst ? m1_ack : m0_ack) && n < 20);
      rd = tbl[k].mst ? m1_rdata : m0_rdata;
      chk("tbl_latency", n, tbl[k].lat);
      chk("tbl_rdata", rd, tbl[k].rdata);
      set_m(tbl[k].mst, 0, 0, 0, 0);
      tick();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    set_m(0, 1, 1, 32'h100, 32'h1111_0000);
    set_m(1, 1, 0, 32'h200, 32'h0);
    bridge_word = 32'h5555_AAAA;
    for (int i = 0; i < 4; i++) begin
      wait_ack(who);
      chk("rr_order", who, i % 2);
      if (who) m1_addr = m1_addr + 4; else m0_addr = m0_addr + 4;
    end
    set_m(0, 0, 0, 0, 0); set_m(1, 0, 0, 0, 0);
    tick();
    set_m(1, 1, 0, 32'h300, 32'h0);
    bridge_word = 32'h7777_1234;
    wait_ack(who); chk("solo_m1_a", who, 1);
    wait_ack(who); chk("solo_m1_b", who, 1);
    set_m(0, 1, 1, 32'h400, 32'h4444_4444);
    wait_ack(who); chk("tie_after_m1", who, 0);
    set_m(0, 0, 0, 0, 0); set_m(1, 0, 0, 0, 0);
    tick();
    set_m(0, 1, 1, 32'h0000_00C0, 32'h0000_0011);
    tick();
    set_m(0, 0, 0, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_wen", wen_to_bridge, 0);
    chk("rst_ack", m0_ack, 0);
    tick(); tick();
    set_m(0, 1, 1, 32'h0000_00C4, 32'h0000_0022);
    set_m(1, 1, 1, 32'h0000_00C8, 32'h0000_0033);
    wait_ack(who); chk("post_rst_tie", who, 0);
    set_m(0, 0, 0, 0, 0);
    wait_ack(who); chk("post_rst_m1", who, 1);
    set_m(1, 0, 0, 0, 0);
    tick();
    set_m(0, 1, 0, 32'h0000_2000, 32'h0);
    bridge_word = 32'h0BAD_F00D;
    tick();
    set_m(0, 0, 0, 0, 0);
    acks = 0;
    repeat (8) begin tick(); if (m0_ack) acks++; end
    chk("drop_acks", acks, 1);
    chk("drop_rdata", m0_rdata, 32'h0BAD_F00D);
    on = '{0, 0}; pend = '{0, 0}; rwen = '{0, 0}; ra = '{0, 0}; rw = '{0, 0};
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++)
        if (cyc == m_ack && m_owner == i[0]) begin pend[i] = 0; on[i] = 0; end
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin on[i] = 0; pend[i] = 0; end
        else if (!on[i] && !pend[i] && $urandom_range(0, 2) == 0) begin
          on[i] = 1; rwen[i] = $urandom_range(0, 1) == 1; ra[i] = $urandom; rw[i] = $urandom;
        end else if (on[i] && pend[i] && $urandom_range(0, 3) == 0) on[i] = 0;
        set_m(i[0], on[i], rwen[i], ra[i], rw[i]);
      end
      bridge_word = $urandom;
      tick();
      if (m_grant == cyc - 1) pend[m_owner] = 1;
    end
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
